sfr_bus_arb: RTL and testbench
==============================

// Module: sfr_bus_arb
// PURPOSE
//  Arbitrates and sequences the external SFR bus: accesses that miss every internal
//  SFR (internal-hit flag low) go to off-core peripheral SFRs. Two requesters share
//  the bus: the CPU core and a debug master (I2C-to-SFR bridge). The CPU is stalled
//  with sfrwait until the peripheral acks. A timeout guards against dead peripherals.
// PARAMETERS
//  TOUT_W    4    width of the timeout counter
//  TOUT_MAX  15   bus-phase cycles without ack before forced termination (1..2^TOUT_W-1)
// PORTS
//  clkcpu       in   1  CPU clock; all state updates on the rising edge
//  rst          in   1  asynchronous reset, active high
//  cpu_sfraddr  in   7  CPU SFR address (SFR space 0x80-0xFF, bit 7 dropped)
//  cpu_sfrdatao in   8  CPU write data
//  cpu_sfrwe    in   1  CPU SFR write strobe; held while sfrwait=1
//  cpu_sfroe    in   1  CPU SFR read strobe; held while sfrwait=1
//  cpu_int_hit  in   1  1 = address decodes to an internal SFR; arbiter ignores the access
//  sfrwait      out  1  CPU stall request
//  cpu_sfrdatai out  8  external read data to the SFR read mux
//  dbg_req      in   1  debug request level; held until dbg_done
//  dbg_we       in   1  1 = write, 0 = read; stable with dbg_req
//  dbg_addr     in   7  debug SFR address
//  dbg_wdat     in   8  debug write data
//  dbg_gnt      out  1  debug owns the bus (DBG_BUS state)
//  dbg_done     out  1  one-cycle completion pulse
//  dbg_rdat     out  8  debug read data; valid with dbg_done, held until next debug read
//  esfr_addr    out  7  external bus address (registered)
//  esfr_wdat    out  8  external bus write data (registered)
//  esfr_we      out  1  external write strobe, high for the whole bus phase
//  esfr_oe      out  1  external read strobe, high for the whole bus phase
//  esfr_rdat    in   8  peripheral read data; sampled in the esfr_ack cycle
//  esfr_ack     in   1  peripheral completion, single cycle
//  tout_err     out  1  sticky timeout flag
//  tout_clr     in   1  clears tout_err
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: esfr_*, dbg_*, cpu_sfrdatai, tout_err.
//   Timeout counter=0. last_gnt=DBG, so the CPU wins the first tie.
//   sfrwait is forced to 0 while rst=1.
//  cpu_req = (cpu_sfroe|cpu_sfrwe) & ~cpu_int_hit.
//  FSM states: IDLE, CPU_BUS, CPU_END, DBG_BUS, DBG_END.
//  IDLE:
//   - If only cpu_req, go to CPU_BUS. If only dbg_req, go to DBG_BUS.
//   - If both, grant the requester that is not last_gnt (round-robin).
//   - On the entering edge, latch addr/wdat/we/oe into esfr_*, clear the
//     counter, and update last_gnt.
//  CPU_BUS / DBG_BUS:
//   - esfr_* are held stable. The counter increments each cycle that esfr_ack=0.
//   - Terminate when esfr_ack=1 or when the counter reaches TOUT_MAX.
//   - On termination, drop esfr_we/oe on the next edge and go to *_END.
//   - Read data capture on ack: esfr_rdat. Capture on timeout: 8'hFF.
//   - Timeout also sets tout_err. Ack and timeout in the same cycle: ack wins,
//     no error is flagged.
//  CPU_END: sfrwait=0; cpu_sfrdatai holds the captured data. Next state is IDLE.
//   The CPU presents a new access in the following cycle.
//  DBG_END: dbg_done=1 for exactly one cycle. dbg_rdat updates on reads only.
//   Next state is IDLE.
//  sfrwait is combinational: cpu_req & ~(state==CPU_END).
//   It is therefore also high during IDLE and while the debug master owns the bus.
//  Minimum CPU external access: request in cycle N, bus phase N+1, ack in N+1,
//   END in N+2. sfrwait is high in N and N+1 (2 stall cycles).
//  Write strobes: esfr_we=1 only on write accesses; esfr_oe=1 only on reads.
//   If the CPU asserts both strobes, the access is a write.
//  tout_clr and a new timeout in the same cycle: set wins.
//  dbg_req dropped mid-transfer is ignored; the transfer completes and dbg_done pulses.
//  An ack arriving outside a *_BUS state is ignored.
//  Async reset mid-transfer: strobes drop immediately, no dbg_done pulse,
//   captured data is cleared.
// TESTING
//  1. CPU read 0x45, ack on the 3rd bus cycle, rdat=8'hA5
//     -> sfrwait high 4 cycles, cpu_sfrdatai=8'hA5 in CPU_END, tout_err=0.
//  2. Debug write addr 0x30, wdat 8'h5C, immediate ack
//     -> esfr_we=1 for 1 cycle with addr/data; one dbg_done pulse; dbg_rdat unchanged.
//  3. CPU and debug request in the same IDLE cycle after reset
//     -> CPU granted first, debug next. On the next tie, debug wins.
//  4. CPU read, no ack
//     -> termination after exactly 15 bus cycles, cpu_sfrdatai=8'hFF, tout_err=1.
//     Then tout_clr=1 -> tout_err=0.
//  5. Ack in the TOUT_MAX cycle -> captured rdat used, tout_err stays 0.
//     Separately, tout_clr coincident with a timeout -> tout_err=1.
//  6. rst pulsed during DBG_BUS -> esfr_oe/dbg_gnt drop asynchronously,
//     no dbg_done, state IDLE.
//     cpu_int_hit=1 with cpu_sfroe -> no bus activity, sfrwait=0.

Source files
------------

// File: rtl/sfr_bus_arb.sv
// sfr_bus_arb: arbitrates the off-core SFR bus between the CPU and a debug master.
// It runs one transfer at a time with round-robin on ties, and stalls the CPU
// with sfrwait until its transfer ends. A cycle counter force-terminates a bus
// phase that never receives an ack.
module sfr_bus_arb #(
    parameter int TOUT_W   = 4,
    parameter int TOUT_MAX = 15
) (
    input  logic       clkcpu,
    input  logic       rst,
    input  logic [6:0] cpu_sfraddr,
    input  logic [7:0] cpu_sfrdatao,
    input  logic       cpu_sfrwe,
    input  logic       cpu_sfroe,
    input  logic       cpu_int_hit,
    output logic       sfrwait,
    output logic [7:0] cpu_sfrdatai,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [6:0] dbg_addr,
    input  logic [7:0] dbg_wdat,
    output logic       dbg_gnt,
    output logic       dbg_done,
    output logic [7:0] dbg_rdat,
    output logic [6:0] esfr_addr,
    output logic [7:0] esfr_wdat,
    output logic       esfr_we,
    output logic       esfr_oe,
    input  logic [7:0] esfr_rdat,
    input  logic       esfr_ack,
    output logic       tout_err,
    input  logic       tout_clr
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_BUS = 3'd1,
        CPU_END = 3'd2,
        DBG_BUS = 3'd3,
        DBG_END = 3'd4
    } state_t;

    // Counter value seen during the last bus cycle allowed before forced termination
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TOUT_MAX - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic              last_dbg_r;     // 1 = debug held the bus most recently
    logic [TOUT_W-1:0] tout_cnt_r;
    logic              cpu_req_s;
    logic              grant_cpu_s;
    logic              grant_dbg_s;
    logic              bus_phase_s;
    logic              tout_hit_s;
    logic              bus_done_s;
    logic [7:0]        cap_data_s;

    assign cpu_req_s   = (cpu_sfroe | cpu_sfrwe) & ~cpu_int_hit;
    assign bus_phase_s = (state_r == CPU_BUS) || (state_r == DBG_BUS);
    // An ack in the last allowed cycle wins over the timeout
    assign tout_hit_s  = bus_phase_s & ~esfr_ack & (tout_cnt_r == TOUT_LAST);
    assign bus_done_s  = bus_phase_s & (esfr_ack | tout_hit_s);
    // Without an ack the bus phase ended by timeout, so reads return all ones
    assign cap_data_s  = esfr_ack ? esfr_rdat : 8'hFF;
    // The stall is released only in the CPU's end cycle and is forced low in reset
    assign sfrwait     = ~rst & cpu_req_s & (state_r != CPU_END);

    // Round-robin grant decision, only taken from IDLE
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dbg_s = 1'b0;
        if (state_r == IDLE) begin
            if (cpu_req_s && dbg_req) begin
                grant_cpu_s = last_dbg_r;
                grant_dbg_s = ~last_dbg_r;
            end else begin
                grant_cpu_s = cpu_req_s;
                grant_dbg_s = dbg_req;
            end
        end else begin
            grant_cpu_s = 1'b0;
            grant_dbg_s = 1'b0;
        end
    end

    // Next-state logic of the transfer sequencer
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_cpu_s) begin
                    next_state_s = CPU_BUS;
                end else if (grant_dbg_s) begin
                    next_state_s = DBG_BUS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CPU_BUS: begin
                if (bus_done_s) begin
                    next_state_s = CPU_END;
                end else begin
                    next_state_s = CPU_BUS;
                end
            end
            DBG_BUS: begin
                if (bus_done_s) begin
                    next_state_s = DBG_END;
                end else begin
                    next_state_s = DBG_BUS;
                end
            end
            CPU_END: next_state_s = IDLE;
            DBG_END: next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clkcpu or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Debug handshake outputs registered from the next state
    always_ff @(posedge clkcpu or posedge rst) begin
        if (rst) begin
            dbg_gnt  <= 1'b0;
            dbg_done <= 1'b0;
        end else begin
            dbg_gnt  <= (next_state_s == DBG_BUS);
            dbg_done <= (next_state_s == DBG_END);
        end
    end

    // Remember the last winner so the other requester wins the next tie
    always_ff @(posedge clkcpu or posedge rst) begin
        if (rst) begin
            last_dbg_r <= 1'b1;
        end else if (grant_cpu_s) begin
            last_dbg_r <= 1'b0;
        end else if (grant_dbg_s) begin
            last_dbg_r <= 1'b1;
        end
    end

    // External bus address/data/strobes: latched on grant, strobes dropped on termination
    always_ff @(posedge clkcpu or posedge rst) begin
        if (rst) begin
            esfr_addr <= 7'h00;
            esfr_wdat <= 8'h00;
            esfr_we   <= 1'b0;
            esfr_oe   <= 1'b0;
        end else if (grant_cpu_s) begin
            esfr_addr <= cpu_sfraddr;
            esfr_wdat <= cpu_sfrdatao;
            esfr_we   <= cpu_sfrwe;
            esfr_oe   <= cpu_sfroe & ~cpu_sfrwe;
        end else if (grant_dbg_s) begin
            esfr_addr <= dbg_addr;
            esfr_wdat <= dbg_wdat;
            esfr_we   <= dbg_we;
            esfr_oe   <= ~dbg_we;
        end else if (bus_done_s) begin
            esfr_we   <= 1'b0;
            esfr_oe   <= 1'b0;
        end
    end

    // Bus-phase cycle counter: cleared on grant, counts cycles without ack
    always_ff @(posedge clkcpu or posedge rst) begin
        if (rst) begin
            tout_cnt_r <= '0;
        end else if (grant_cpu_s || grant_dbg_s) begin
            tout_cnt_r <= '0;
        end else if (bus_phase_s && !esfr_ack) begin
            tout_cnt_r <= tout_cnt_r + TOUT_W'(1);
        end
    end

    // Read data capture at the end of a read bus phase, steered to its owner
    always_ff @(posedge clkcpu or posedge rst) begin
        if (rst) begin
            cpu_sfrdatai <= 8'h00;
            dbg_rdat     <= 8'h00;
        end else if (bus_done_s && esfr_oe) begin
            if (state_r == CPU_BUS) begin
                cpu_sfrdatai <= cap_data_s;
            end else begin
                dbg_rdat <= cap_data_s;
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clkcpu or posedge rst) begin
        if (rst) begin
            tout_err <= 1'b0;
        end else if (tout_hit_s) begin
            tout_err <= 1'b1;
        end else if (tout_clr) begin
            tout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sfr_bus_arb.sv
// Testbench for sfr_bus_arb: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_sfr_bus_arb;

    localparam int TOUT_MAX = 15;
    localparam int NONE = 0;
    localparam int CPU  = 1;
    localparam int DBG  = 2;

    logic       clkcpu = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cpu_sfraddr = 7'h00;
    logic [7:0] cpu_sfrdatao = 8'h00;
    logic       cpu_sfrwe = 1'b0;
    logic       cpu_sfroe = 1'b0;
    logic       cpu_int_hit = 1'b0;
    logic       sfrwait;
    logic [7:0] cpu_sfrdatai;
    logic       dbg_req = 1'b0;
    logic       dbg_we = 1'b0;
    logic [6:0] dbg_addr = 7'h00;
    logic [7:0] dbg_wdat = 8'h00;
    logic       dbg_gnt;
    logic       dbg_done;
    logic [7:0] dbg_rdat;
    logic [6:0] esfr_addr;
    logic [7:0] esfr_wdat;
    logic       esfr_we;
    logic       esfr_oe;
    logic [7:0] esfr_rdat = 8'h00;
    logic       esfr_ack = 1'b0;
    logic       tout_err;
    logic       tout_clr = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    logic cmp_en = 1'b0;

    sfr_bus_arb #(.TOUT_W(4), .TOUT_MAX(TOUT_MAX)) dut (
        .clkcpu(clkcpu), .rst(rst),
        .cpu_sfraddr(cpu_sfraddr), .cpu_sfrdatao(cpu_sfrdatao),
        .cpu_sfrwe(cpu_sfrwe), .cpu_sfroe(cpu_sfroe), .cpu_int_hit(cpu_int_hit),
        .sfrwait(sfrwait), .cpu_sfrdatai(cpu_sfrdatai),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdat(dbg_wdat),
        .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdat(dbg_rdat),
        .esfr_addr(esfr_addr), .esfr_wdat(esfr_wdat), .esfr_we(esfr_we), .esfr_oe(esfr_oe),
        .esfr_rdat(esfr_rdat), .esfr_ack(esfr_ack),
        .tout_err(tout_err), .tout_clr(tout_clr)
    );

    // Free-running CPU clock
    initial forever #5 clkcpu = ~clkcpu;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // bus_who: who owns a running bus phase; end_who: who sees its end cycle now.
    int         bus_who, end_who, bus_cyc, last_who, m_win;
    logic [6:0] m_addr;
    logic [7:0] m_wdat, m_cpu_rd, m_dbg_rd;
    logic       m_we, m_oe, m_tout, m_cpu_hold, m_dbg_fin, m_cpu_req, m_fin, m_tnow;

    initial forever begin
        @(posedge clkcpu or posedge rst);
        if (rst) begin
            bus_who = NONE; end_who = NONE; bus_cyc = 0; last_who = DBG;
            m_addr = 7'h00; m_wdat = 8'h00; m_we = 1'b0; m_oe = 1'b0;
            m_cpu_rd = 8'h00; m_dbg_rd = 8'h00; m_tout = 1'b0;
            m_cpu_hold = 1'b0; m_dbg_fin = 1'b0;
        end else begin
            m_cpu_req  = (cpu_sfroe | cpu_sfrwe) & ~cpu_int_hit;
            m_cpu_hold = m_cpu_req && (end_who != CPU);
            m_dbg_fin  = (end_who == DBG);
            m_fin = 1'b0;
            m_tnow = 1'b0;
            if (end_who != NONE) begin
                end_who = NONE;
            end else if (bus_who != NONE) begin
                bus_cyc++;
                if (esfr_ack) begin
                    m_fin = 1'b1;
                    if (m_oe && bus_who == CPU) m_cpu_rd = esfr_rdat;
                    if (m_oe && bus_who == DBG) m_dbg_rd = esfr_rdat;
                end else if (bus_cyc == TOUT_MAX) begin
                    m_fin = 1'b1;
                    m_tnow = 1'b1;
                    if (m_oe && bus_who == CPU) m_cpu_rd = 8'hFF;
                    if (m_oe && bus_who == DBG) m_dbg_rd = 8'hFF;
                end
                if (m_fin) begin
                    end_who = bus_who;
                    bus_who = NONE;
                end
            end else begin
                m_win = NONE;
                if (m_cpu_req && dbg_req) m_win = (last_who == CPU) ? DBG : CPU;
                else if (m_cpu_req) m_win = CPU;
                else if (dbg_req) m_win = DBG;
                if (m_win == CPU) begin
                    m_addr = cpu_sfraddr; m_wdat = cpu_sfrdatao;
                    m_we = cpu_sfrwe; m_oe = cpu_sfroe & ~cpu_sfrwe;
                end else if (m_win == DBG) begin
                    m_addr = dbg_addr; m_wdat = dbg_wdat;
                    m_we = dbg_we; m_oe = ~dbg_we;
                end
                if (m_win != NONE) begin
                    bus_who = m_win;
                    bus_cyc = 0;
                    last_who = m_win;
                end
            end
            if (m_tnow) m_tout = 1'b1;
            else if (tout_clr) m_tout = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clkcpu);
        #2;
        if (cmp_en && !rst) begin
            chk("sfrwait", 32'(sfrwait),
                32'((((cpu_sfroe | cpu_sfrwe) & ~cpu_int_hit) == 1'b1) && (end_who != CPU)));
            chk("esfr_we", 32'(esfr_we), 32'((bus_who != NONE) && m_we));
            chk("esfr_oe", 32'(esfr_oe), 32'((bus_who != NONE) && m_oe));
            chk("esfr_addr", 32'(esfr_addr), 32'(m_addr));
            chk("esfr_wdat", 32'(esfr_wdat), 32'(m_wdat));
            chk("dbg_gnt", 32'(dbg_gnt), 32'(bus_who == DBG));
            chk("dbg_done", 32'(dbg_done), 32'(end_who == DBG));
            chk("dbg_rdat", 32'(dbg_rdat), 32'(m_dbg_rd));
            chk("cpu_sfrdatai", 32'(cpu_sfrdatai), 32'(m_cpu_rd));
            chk("tout_err", 32'(tout_err), 32'(m_tout));
        end
    end

    // One CPU access; the peripheral acks on bus cycle ack_at (0 = never)
    task automatic cpu_access(input logic we, input logic [6:0] a, input logic [7:0] d,
                              input int ack_at, input logic [7:0] rd,
                              output int stall, output int bc, output logic [7:0] got,
                              output logic tout_end, output logic ok);
        @(negedge clkcpu);
        cpu_sfrwe = we; cpu_sfroe = ~we; cpu_sfraddr = a; cpu_sfrdatao = d; esfr_ack = 1'b0;
        stall = 0; bc = 0; ok = 1'b0; got = 8'h00; tout_end = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clkcpu);
            if (esfr_we | esfr_oe) begin
                bc++;
                esfr_ack = (bc == ack_at);
                esfr_rdat = rd;
            end else begin
                esfr_ack = 1'b0;
            end
            #3;
            if (!sfrwait) begin
                got = cpu_sfrdatai; tout_end = tout_err; ok = 1'b1;
                break;
            end
            stall++;
        end
        @(negedge clkcpu);
        cpu_sfrwe = 1'b0; cpu_sfroe = 1'b0; esfr_ack = 1'b0;
    endtask

    // One debug access; counts bus cycles and done pulses
    task automatic dbg_access(input logic we, input logic [6:0] a, input logic [7:0] d,
                              input int ack_at, input logic [7:0] rd,
                              output int bc, output int done_cnt, output logic [7:0] rdat,
                              output logic [6:0] seen_a, output logic [7:0] seen_d);
        @(negedge clkcpu);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdat = d; esfr_ack = 1'b0;
        bc = 0; done_cnt = 0; rdat = 8'h00; seen_a = 7'h00; seen_d = 8'h00;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clkcpu);
            if (esfr_we | esfr_oe) begin
                bc++;
                seen_a = esfr_addr; seen_d = esfr_wdat;
                esfr_ack = (bc == ack_at);
                esfr_rdat = rd;
            end else begin
                esfr_ack = 1'b0;
            end
            #3;
            if (dbg_done) begin
                done_cnt++; rdat = dbg_rdat;
                break;
            end
        end
        @(negedge clkcpu);
        dbg_req = 1'b0; esfr_ack = 1'b0;
        #3;
        if (dbg_done) done_cnt++;
    endtask

    int         stall, bc, done_cnt, p_ack, r;
    logic [7:0] got, rdat, seen_d;
    logic [6:0] seen_a;
    logic       tend, ok, granted;

    initial begin
        // Reset state, with a CPU strobe present to show sfrwait is forced low
        repeat (3) @(negedge clkcpu);
        cpu_sfroe = 1'b1;
        #3;
        chk("rst_sfrwait", 32'(sfrwait), 32'd0);
        chk("rst_esfr_oe", 32'(esfr_oe), 32'd0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_tout_err", 32'(tout_err), 32'd0);
        chk("rst_cpu_sfrdatai", 32'(cpu_sfrdatai), 32'd0);

        // Tie right after reset: CPU first, then the next tie goes to debug
        @(negedge clkcpu);
        rst = 1'b0; cmp_en = 1'b1;
        cpu_sfraddr = 7'h11; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h22; dbg_wdat = 8'h33;
        #3; chk("t3_idle_wait", 32'(sfrwait), 32'd1);
        @(negedge clkcpu); esfr_ack = 1'b1; esfr_rdat = 8'h77;
        #3; chk("t3_cpu_first", 32'(esfr_addr), 32'h11); chk("t3_no_dbg", 32'(dbg_gnt), 32'd0);
        @(negedge clkcpu); esfr_ack = 1'b0;
        #3; chk("t3_cpu_end", 32'(sfrwait), 32'd0); chk("t3_cpu_data", 32'(cpu_sfrdatai), 32'h77);
        @(negedge clkcpu); cpu_sfraddr = 7'h12;
        #3; chk("t3_tie2_wait", 32'(sfrwait), 32'd1);
        @(negedge clkcpu); esfr_ack = 1'b1;
        #3; chk("t3_dbg_wins", 32'(dbg_gnt), 32'd1); chk("t3_dbg_addr", 32'(esfr_addr), 32'h22);
        @(negedge clkcpu); esfr_ack = 1'b0;
        #3; chk("t3_dbg_done", 32'(dbg_done), 32'd1);
        @(negedge clkcpu); dbg_req = 1'b0;
        @(negedge clkcpu); esfr_ack = 1'b1; esfr_rdat = 8'h99;
        #3; chk("t3_cpu_again", 32'(esfr_addr), 32'h12);
        @(negedge clkcpu); esfr_ack = 1'b0;
        #3; chk("t3_cpu_data2", 32'(cpu_sfrdatai), 32'h99);
        @(negedge clkcpu); cpu_sfroe = 1'b0;

        // CPU read 0x45, ack on the 3rd bus cycle
        cpu_access(1'b0, 7'h45, 8'h00, 3, 8'hA5, stall, bc, got, tend, ok);
        chk("t1_ended", 32'(ok), 32'd1);
        chk("t1_stall", 32'(stall), 32'd4);
        chk("t1_data", 32'(got), 32'hA5);
        chk("t1_tout", 32'(tend), 32'd0);

        // Debug read to preload dbg_rdat, then a debug write with immediate ack
        dbg_access(1'b0, 7'h31, 8'h00, 2, 8'h6B, bc, done_cnt, rdat, seen_a, seen_d);
        chk("t2_pre_rdat", 32'(rdat), 32'h6B);
        dbg_access(1'b1, 7'h30, 8'h5C, 1, 8'hEE, bc, done_cnt, rdat, seen_a, seen_d);
        chk("t2_we_cycles", 32'(bc), 32'd1);
        chk("t2_addr", 32'(seen_a), 32'h30);
        chk("t2_wdat", 32'(seen_d), 32'h5C);
        chk("t2_done_pulses", 32'(done_cnt), 32'd1);
        chk("t2_rdat_kept", 32'(rdat), 32'h6B);

        // CPU read with no ack: timeout after 15 bus cycles, then clear
        cpu_access(1'b0, 7'h50, 8'h00, 0, 8'h12, stall, bc, got, tend, ok);
        chk("t4_bus_cycles", 32'(bc), 32'd15);
        chk("t4_stall", 32'(stall), 32'd16);
        chk("t4_data", 32'(got), 32'hFF);
        chk("t4_tout", 32'(tend), 32'd1);
        tout_clr = 1'b1;
        @(negedge clkcpu); tout_clr = 1'b0;
        #3; chk("t4_cleared", 32'(tout_err), 32'd0);

        // Ack in the last allowed cycle wins over the timeout
        cpu_access(1'b0, 7'h51, 8'h00, 15, 8'h3C, stall, bc, got, tend, ok);
        chk("t5_bus_cycles", 32'(bc), 32'd15);
        chk("t5_data", 32'(got), 32'h3C);
        chk("t5_tout", 32'(tend), 32'd0);
        // Clear held during a timeout: the set wins
        tout_clr = 1'b1;
        cpu_access(1'b1, 7'h52, 8'h44, 0, 8'h00, stall, bc, got, tend, ok);
        chk("t5_set_wins", 32'(tend), 32'd1);
        @(negedge clkcpu); tout_clr = 1'b0;
        #3; chk("t5_cleared", 32'(tout_err), 32'd0);

        // Reset during a debug read bus phase
        @(negedge clkcpu);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h40; esfr_ack = 1'b0;
        granted = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clkcpu);
            #3;
            if (dbg_gnt) begin granted = 1'b1; break; end
        end
        chk("t6_granted", 32'(granted), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_oe_drop", 32'(esfr_oe), 32'd0);
        chk("t6_gnt_drop", 32'(dbg_gnt), 32'd0);
        chk("t6_rdat_clr", 32'(dbg_rdat), 32'd0);
        @(negedge clkcpu); rst = 1'b0; dbg_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3; chk("t6_no_done", 32'(dbg_done | dbg_gnt | esfr_oe), 32'd0);
            @(negedge clkcpu);
        end
        // Internal hit: no external activity, no stall
        cpu_int_hit = 1'b1; cpu_sfroe = 1'b1; cpu_sfraddr = 7'h05;
        for (int k = 0; k < 3; k++) begin
            #3; chk("t6_int_hit", 32'(sfrwait | esfr_oe), 32'd0);
            @(negedge clkcpu);
        end
        cpu_int_hit = 1'b0; cpu_sfroe = 1'b0;

        // Randomized traffic, checked cycle by cycle by the model compare
        p_ack = 30;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clkcpu);
            if (n % 250 == 0) begin
                r = $urandom_range(0, 3);
                p_ack = (r == 0) ? 0 : (r == 1) ? 6 : (r == 2) ? 30 : 75;
            end
            if (!m_cpu_hold) begin
                r = $urandom_range(0, 9);
                cpu_sfraddr = 7'($urandom); cpu_sfrdatao = 8'($urandom);
                cpu_int_hit = (r == 3);
                cpu_sfroe = (r >= 3 && r <= 6) || (r == 9);
                cpu_sfrwe = (r == 7) || (r == 8) || (r == 9);
            end
            if (dbg_req) begin
                if (m_dbg_fin) begin
                    dbg_req = ($urandom_range(0, 2) == 0);
                    dbg_we = 1'($urandom); dbg_addr = 7'($urandom); dbg_wdat = 8'($urandom);
                end else if (bus_who == DBG && $urandom_range(0, 15) == 0) begin
                    dbg_req = 1'b0;
                end
            end else if (bus_who != DBG && end_who != DBG && $urandom_range(0, 3) == 0) begin
                dbg_req = 1'b1;
                dbg_we = 1'($urandom); dbg_addr = 7'($urandom); dbg_wdat = 8'($urandom);
            end
            esfr_ack = ($urandom_range(0, 99) < p_ack);
            esfr_rdat = 8'($urandom);
            tout_clr = ($urandom_range(0, 15) == 0);
        end
        @(negedge clkcpu);
        cpu_sfroe = 1'b0; cpu_sfrwe = 1'b0; dbg_req = 1'b0; esfr_ack = 1'b0; tout_clr = 1'b0;
        repeat (3) @(negedge clkcpu);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
